branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-side branch predictor and target buffer for the five-stage pipeline. It supplies the `Predict`/`Prediction` pair that the PC update logic consumes in the I stage. It carries each prediction alongside its instruction through R into C and reports `PredictionCorrect_C` once the branch or jump resolves. On that same C-stage resolution it trains a direct-mapped table of 2-bit saturating counters and targets.

## Interface
Parameters
- `ENTRIES`, 16: number of table entries; must be a power of two, minimum 2.
- Data width is `` `BIT_COUNT `` from parameters.svh; it is not a parameter.

Ports
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `PC_I` in `BIT_COUNT`: fetch PC.
- `Predict` out 1: the fetch instruction is predicted taken.
- `Prediction` out `BIT_COUNT`: predicted target, bit 0 forced to 0.
- `EnableR` in 1: the R-stage prediction register loads from I.
- `FlushR` in 1: clears the R-stage register; wins over `EnableR`.
- `EnableC` in 1: the C-stage register loads from R; also means the current C instruction leaves C this cycle.
- `FlushC` in 1: clears the C-stage register; wins over `EnableC`.
- `PCSrcPostConditional_C` in `pcSrc`: `Branch_C` or `Jump_C` marks a resolving control instruction.
- `ResolvedTaken_C` in 1: the branch outcome; ignored for `Jump_C`, which is always taken.
- `ResolvedTarget_C` in `BIT_COUNT`: the actual taken target.
- `PredictionCorrect_C` out 1: the C-stage prediction matched the resolution.

## Operation
Table and indexing
- `IDX = $clog2(ENTRIES)`.
- Index is `PC[IDX+1:2]`; tag is `PC[BIT_COUNT-1:IDX+2]`.
- Each entry holds `valid`, `tag`, `isJump`, a 2-bit counter and a target.

Lookup (combinational, I stage)
- Hit = valid and tag match.
- `Predict` = hit and (`isJump` or counter ≥ WeakT).
- `Prediction` = stored target when hit, otherwise 0.

Stage registers
- R holds {valid, PC, predTaken, predTarget}.
- C holds the same fields, loaded from R.
- A flushed stage has valid = 0.

Correctness check
- `PredictionCorrect_C` = C.valid AND control-in-C AND (C.predTaken == actualTaken) AND (!actualTaken OR C.predTarget == ResolvedTarget_C).
- It is 0 whenever no control instruction is in C.

Training
- Training fires once per instruction, in the cycle C.valid & control-in-C & `EnableC` & !`FlushC`. A stall therefore never trains twice.
- On a hit:
  - Branch: the counter saturates up if taken, down if not taken.
  - Jump: the counter is set to StrongT.
  - If taken, the target is overwritten.
- On a miss:
  - Taken: allocate, replacing the old entry unconditionally. Set the tag, `isJump`, the target, and the counter to WeakT (StrongT for a jump).
  - Not taken: no change.
- Counter encoding: StrongNT=00, WeakNT=01, WeakT=10, StrongT=11.

## Timing
Reset
- All entries: valid=0, counter=WeakNT, tag=0, target=0.
- R and C registers cleared.
- `Predict`=0, `Prediction`=0, `PredictionCorrect_C`=0, combinationally while `reset` is high.
- A reset mid-operation discards all training and any in-flight predictions.

Latency
- Lookup is zero-cycle.
- A training write is visible to lookups on the next cycle.
- When a lookup and a write hit the same index in the same cycle, the lookup sees the old contents. There is no bypass.

Stalls and flushes
- With `EnableR`=0 (and no flush), R holds its contents; the same holds for C with `EnableC`=0.
- A flush in the same cycle as an enable clears the stage.
- A flushed C instruction never trains.

## Structure
- Add to the `HighLevelControl` package:
  - a `bpCounter` enum covering the four counter states;
  - a packed `bpStage` struct for the R/C register fields.
- `pcSrc` is reused unchanged from that package.
- One natural sub-module, `branch_target_table`, holds the storage array, the async-reset clearing, the read port and the write/allocate port.
- The top module holds the stage registers, the counter-update function and the correctness compare.

## Test plan
All scenarios use `BIT_COUNT`=32 and `ENTRIES`=16.
1. Reset, then `PC_I`=0x100 → `Predict`=0 and `Prediction`=0; `PredictionCorrect_C`=0 with nothing in C.
2. Branch at 0x100 resolves taken to 0x80 (predicted not taken) → `PredictionCorrect_C`=0. Next cycle, `PC_I`=0x100 → `Predict`=1, `Prediction`=0x80, counter WeakT.
3. Two further not-taken resolutions of 0x100 → counter StrongNT and `Predict`=0. One taken resolution → WeakNT, still `Predict`=0.
4. Aliasing: after training 0x100, lookup 0x140 (same index 0, different tag) → `Predict`=0. A taken 0x140 resolution replaces the entry, and 0x100 then misses.
5. Jump at 0x200 to 0x300 is allocated with StrongT; its next pass → `PredictionCorrect_C`=1.
   - A later pass resolving to 0x304 → `PredictionCorrect_C`=0, and the target becomes 0x304.
   - The jump held in C with `EnableC`=0 for 3 cycles → exactly one training write.
6. Training write and lookup of 0x100 in the same cycle → old prediction returned. `FlushC` with a taken branch in C → no table change. `reset` pulsed mid-run → all outputs 0 and the table empty.

Source files
------------

// File: rtl/HighLevelControl.sv
// Shared control-path types: PC source select plus the branch predictor's
// counter encoding and pipeline stage record.
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

package HighLevelControl;

  // Source of the next PC as decided after the conditional check in C.
  typedef enum logic [1:0] {
    Step_C   = 2'b00,
    Branch_C = 2'b01,
    Jump_C   = 2'b10,
    Trap_C   = 2'b11
  } pcSrc;

  // 2-bit saturating direction counter; the MSB is the taken prediction.
  typedef enum logic [1:0] {
    StrongNT = 2'b00,
    WeakNT   = 2'b01,
    WeakT    = 2'b10,
    StrongT  = 2'b11
  } bpCounter;

  // Prediction carried alongside an instruction through R and C.
  typedef struct packed {
    logic                  valid;
    logic [`BIT_COUNT-1:0] pc;
    logic                  predTaken;
    logic [`BIT_COUNT-1:0] predTarget;
  } bpStage;

endpackage

// File: rtl/branch_target_table.sv
// Direct-mapped predictor storage: one lookup port for fetch, one read port
// for the resolving C-stage instruction, and one write/allocate port.
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module branch_target_table
  import HighLevelControl::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX     = 4,
  parameter int TAGW    = 26,
  parameter int DW      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IDX-1:0]  lk_idx_i,
  input  logic [TAGW-1:0] lk_tag_i,
  output logic            lk_hit_o,
  output logic            lk_jump_o,
  output bpCounter        lk_ctr_o,
  output logic [DW-1:0]   lk_target_o,
  input  logic [IDX-1:0]  tr_idx_i,
  input  logic [TAGW-1:0] tr_tag_i,
  output logic            tr_hit_o,
  output bpCounter        tr_ctr_o,
  output logic [DW-1:0]   tr_target_o,
  input  logic            wr_en_i,
  input  logic [IDX-1:0]  wr_idx_i,
  input  logic [TAGW-1:0] wr_tag_i,
  input  logic            wr_jump_i,
  input  bpCounter        wr_ctr_i,
  input  logic [DW-1:0]   wr_target_i
);

  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic            jump_q   [ENTRIES];
  bpCounter        ctr_q    [ENTRIES];
  logic [DW-1:0]   target_q [ENTRIES];

  // Reads are purely combinational; a same-cycle write is not bypassed.
  assign lk_hit_o    = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
  assign lk_jump_o   = jump_q[lk_idx_i];
  assign lk_ctr_o    = ctr_q[lk_idx_i];
  assign lk_target_o = target_q[lk_idx_i];

  assign tr_hit_o    = valid_q[tr_idx_i] && (tag_q[tr_idx_i] == tr_tag_i);
  assign tr_ctr_o    = ctr_q[tr_idx_i];
  assign tr_target_o = target_q[tr_idx_i];

  // Clear every entry on reset; otherwise apply the single training write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        jump_q[i]   <= 1'b0;
        ctr_q[i]    <= WeakNT;
        target_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      valid_q[wr_idx_i]  <= 1'b1;
      tag_q[wr_idx_i]    <= wr_tag_i;
      jump_q[wr_idx_i]   <= wr_jump_i;
      ctr_q[wr_idx_i]    <= wr_ctr_i;
      target_q[wr_idx_i] <= wr_target_i;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: zero-cycle lookup in I, prediction carried
// through R and C, correctness report and table training on C resolution.
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module branch_predictor
  import HighLevelControl::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [`BIT_COUNT-1:0] PC_I,
  output logic                  Predict,
  output logic [`BIT_COUNT-1:0] Prediction,
  input  logic                  EnableR,
  input  logic                  FlushR,
  input  logic                  EnableC,
  input  logic                  FlushC,
  input  pcSrc                  PCSrcPostConditional_C,
  input  logic                  ResolvedTaken_C,
  input  logic [`BIT_COUNT-1:0] ResolvedTarget_C,
  output logic                  PredictionCorrect_C
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = `BIT_COUNT - IDX - 2;

  // Next counter value after a resolution that hit the table.
  function automatic bpCounter bp_next_counter(input bpCounter cur, input logic taken,
                                               input logic is_jump);
    bpCounter nxt;
    if (is_jump) begin
      nxt = StrongT;
    end else if (taken) begin
      nxt = (cur == StrongT) ? StrongT : bpCounter'(cur + 2'd1);
    end else begin
      nxt = (cur == StrongNT) ? StrongNT : bpCounter'(cur - 2'd1);
    end
    return nxt;
  endfunction

  bpStage r_q, r_d, c_q, c_d;

  logic                  lk_hit_s, lk_jump_s, tr_hit_s;
  bpCounter              lk_ctr_s, tr_ctr_s, wr_ctr_s;
  logic [`BIT_COUNT-1:0] lk_target_s, tr_target_s, wr_target_s;
  logic                  wr_en_s, wr_jump_s;
  logic                  ctrl_c_s, jump_c_s, actual_taken_s, train_s;
  logic                  unused_pc_bits_s;

  branch_target_table #(
    .ENTRIES(ENTRIES),
    .IDX    (IDX),
    .TAGW   (TAGW),
    .DW     (`BIT_COUNT)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .lk_idx_i   (PC_I[IDX+1:2]),
    .lk_tag_i   (PC_I[`BIT_COUNT-1:IDX+2]),
    .lk_hit_o   (lk_hit_s),
    .lk_jump_o  (lk_jump_s),
    .lk_ctr_o   (lk_ctr_s),
    .lk_target_o(lk_target_s),
    .tr_idx_i   (c_q.pc[IDX+1:2]),
    .tr_tag_i   (c_q.pc[`BIT_COUNT-1:IDX+2]),
    .tr_hit_o   (tr_hit_s),
    .tr_ctr_o   (tr_ctr_s),
    .tr_target_o(tr_target_s),
    .wr_en_i    (wr_en_s),
    .wr_idx_i   (c_q.pc[IDX+1:2]),
    .wr_tag_i   (c_q.pc[`BIT_COUNT-1:IDX+2]),
    .wr_jump_i  (wr_jump_s),
    .wr_ctr_i   (wr_ctr_s),
    .wr_target_i(wr_target_s)
  );

  // Instructions are word aligned, so the low PC bits never index or tag.
  assign unused_pc_bits_s = ^{PC_I[1:0], c_q.pc[1:0]};

  // Fetch prediction; forced low while reset is held.
  assign Predict    = !reset && lk_hit_s &&
                      (lk_jump_s || (lk_ctr_s == WeakT) || (lk_ctr_s == StrongT));
  assign Prediction = (!reset && lk_hit_s) ? {lk_target_s[`BIT_COUNT-1:1], 1'b0} : '0;

  // A jump is always taken regardless of ResolvedTaken_C.
  assign jump_c_s       = (PCSrcPostConditional_C == Jump_C);
  assign ctrl_c_s       = (PCSrcPostConditional_C == Branch_C) || jump_c_s;
  assign actual_taken_s = jump_c_s || ResolvedTaken_C;

  assign PredictionCorrect_C = !reset && c_q.valid && ctrl_c_s &&
                               (c_q.predTaken == actual_taken_s) &&
                               (!actual_taken_s || (c_q.predTarget == ResolvedTarget_C));

  // Train only as the instruction leaves C, so stalls never repeat the write.
  assign train_s = c_q.valid && ctrl_c_s && EnableC && !FlushC;

  // Build the table write: update on hit, allocate on a taken miss.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_jump_s   = jump_c_s;
    wr_ctr_s    = tr_ctr_s;
    wr_target_s = tr_target_s;
    if (train_s) begin
      if (tr_hit_s) begin
        wr_en_s     = 1'b1;
        wr_ctr_s    = bp_next_counter(tr_ctr_s, actual_taken_s, jump_c_s);
        wr_target_s = actual_taken_s ? ResolvedTarget_C : tr_target_s;
      end else if (actual_taken_s) begin
        wr_en_s     = 1'b1;
        wr_ctr_s    = jump_c_s ? StrongT : WeakT;
        wr_target_s = ResolvedTarget_C;
      end else begin
        wr_en_s     = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Stage next-state: flush clears, enable advances, otherwise hold.
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    if (FlushR) begin
      r_d = '0;
    end else if (EnableR) begin
      r_d.valid      = 1'b1;
      r_d.pc         = PC_I;
      r_d.predTaken  = Predict;
      r_d.predTarget = Prediction;
    end else begin
      r_d = r_q;
    end
    if (FlushC) begin
      c_d = '0;
    end else if (EnableC) begin
      c_d = r_q;
    end else begin
      c_d = c_q;
    end
  end

  // R and C prediction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a table-of-records reference model
// predicts each cycle's outputs; a negedge monitor pops and compares.
module tb_branch_predictor;
  import HighLevelControl::*;

  localparam int ENTRIES = 16;
  localparam int IDX     = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PC_I = 32'h0;
  logic        Predict;
  logic [31:0] Prediction;
  logic        EnableR = 1'b0, FlushR = 1'b0, EnableC = 1'b0, FlushC = 1'b0;
  pcSrc        PCSrcPostConditional_C = Step_C;
  logic        ResolvedTaken_C = 1'b0;
  logic [31:0] ResolvedTarget_C = 32'h0;
  logic        PredictionCorrect_C;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .PC_I                  (PC_I),
    .Predict               (Predict),
    .Prediction            (Prediction),
    .EnableR               (EnableR),
    .FlushR                (FlushR),
    .EnableC               (EnableC),
    .FlushC                (FlushC),
    .PCSrcPostConditional_C(PCSrcPostConditional_C),
    .ResolvedTaken_C       (ResolvedTaken_C),
    .ResolvedTarget_C      (ResolvedTarget_C),
    .PredictionCorrect_C   (PredictionCorrect_C)
  );

  always #5 clk = ~clk;

  // Reference model: per-index record, counter as a plain integer 0..3.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  bit          m_jump  [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];

  typedef struct { bit v; logic [31:0] pc; bit pt; logic [31:0] ptgt; } slot_t;
  typedef struct { bit p; logic [31:0] t; bit c; } exp_t;

  slot_t r_s, c_s;
  exp_t  sb_q[$];
  exp_t  mon_e;
  int    checks = 0, errors = 0;
  bit    done = 1'b0, end_checked = 1'b0;

  logic [31:0] pcs  [8] = '{32'h100, 32'h140, 32'h200, 32'h104, 32'h108, 32'h1C, 32'h3C, 32'h600};
  logic [31:0] tgts [6] = '{32'h80, 32'h300, 32'h304, 32'h500, 32'h1000, 32'hFFFF_FFF0};
  pcSrc        srcs [4] = '{Step_C, Branch_C, Branch_C, Jump_C};

  function automatic slot_t empty_slot();
    slot_t s;
    s.v = 1'b0; s.pc = 32'h0; s.pt = 1'b0; s.ptgt = 32'h0;
    return s;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_jump[i] = 1'b0; m_ctr[i] = 1; m_tgt[i] = 32'h0;
    end
    r_s = empty_slot();
    c_s = empty_slot();
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output bit p, output logic [31:0] t);
    int          i;
    int unsigned tg;
    i  = int'((pc >> 2) % ENTRIES);
    tg = pc >> (IDX + 2);
    if (m_valid[i] && m_tag[i] == tg) begin
      p = m_jump[i] || (m_ctr[i] >= 2);
      t = m_tgt[i] & 32'hFFFF_FFFE;
    end else begin
      p = 1'b0;
      t = 32'h0;
    end
  endfunction

  // One clock of stimulus; called at posedge+1, records expected outputs.
  task automatic step(input logic [31:0] pc, input bit enr, input bit flr, input bit enc,
                      input bit flc, input pcSrc src, input bit tk, input logic [31:0] tgt);
    exp_t        e;
    bit          ctrl, act, hit;
    int          i;
    int unsigned tg;
    slot_t       nr;
    PC_I = pc; EnableR = enr; FlushR = flr; EnableC = enc; FlushC = flc;
    PCSrcPostConditional_C = src; ResolvedTaken_C = tk; ResolvedTarget_C = tgt;
    model_lookup(pc, e.p, e.t);
    ctrl = (src == Branch_C) || (src == Jump_C);
    act  = (src == Jump_C) || tk;
    e.c  = c_s.v && ctrl && (c_s.pt == act) && (!act || c_s.ptgt == tgt);
    sb_q.push_back(e);
    if (c_s.v && ctrl && enc && !flc) begin
      i   = int'((c_s.pc >> 2) % ENTRIES);
      tg  = c_s.pc >> (IDX + 2);
      hit = m_valid[i] && m_tag[i] == tg;
      if (hit) begin
        if (src == Jump_C)  m_ctr[i] = 3;
        else if (act)       m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        else                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        m_jump[i] = (src == Jump_C);
        if (act) m_tgt[i] = tgt;
      end else if (act) begin
        m_valid[i] = 1'b1; m_tag[i] = tg; m_jump[i] = (src == Jump_C);
        m_ctr[i] = (src == Jump_C) ? 3 : 2; m_tgt[i] = tgt;
      end
    end
    nr.v = 1'b1; nr.pc = pc; nr.pt = e.p; nr.ptgt = e.t;
    if (flc)      c_s = empty_slot();
    else if (enc) c_s = r_s;
    if (flr)      r_s = empty_slot();
    else if (enr) r_s = nr;
    @(posedge clk);
    #1;
  endtask

  // Assert reset for one cycle; all outputs must read zero meanwhile.
  task automatic do_reset();
    exp_t e;
    reset = 1'b1;
    PC_I = 32'h100; EnableR = 1'b1; EnableC = 1'b1; FlushR = 1'b0; FlushC = 1'b0;
    PCSrcPostConditional_C = Branch_C; ResolvedTaken_C = 1'b1; ResolvedTarget_C = 32'h80;
    e.p = 1'b0; e.t = 32'h0; e.c = 1'b0;
    sb_q.push_back(e);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Instruction fetched at pc, resolved when it reaches C (third cycle).
  task automatic run_insn(input logic [31:0] pc, input pcSrc src, input bit tk,
                          input logic [31:0] tgt, input logic [31:0] lpc);
    step(pc,     1'b1, 1'b0, 1'b1, 1'b0, Step_C, 1'b0, 32'h0);
    step(32'h3C, 1'b1, 1'b0, 1'b1, 1'b0, Step_C, 1'b0, 32'h0);
    step(lpc,    1'b1, 1'b0, 1'b1, 1'b0, src, tk, tgt);
  endtask

  // Monitor: compare each cycle's outputs against the oldest expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (Predict !== mon_e.p) begin
        errors++;
        $display("FAIL predict: got %0b expected %0b at %0t", Predict, mon_e.p, $time);
      end
      checks++;
      if (Prediction !== mon_e.t) begin
        errors++;
        $display("FAIL prediction: got %h expected %h at %0t", Prediction, mon_e.t, $time);
      end
      checks++;
      if (PredictionCorrect_C !== mon_e.c) begin
        errors++;
        $display("FAIL correct_c: got %0b expected %0b at %0t", PredictionCorrect_C, mon_e.c, $time);
      end
    end else if (done && !end_checked) begin
      end_checked = 1'b1;
      checks++;
      if (sb_q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      end
    end
  end

  initial begin
    model_clear();
    @(posedge clk);
    #1;
    // 1: reset state, then a control op with nothing valid in C
    do_reset();
    step(32'h100, 1'b1, 1'b0, 1'b1, 1'b0, Branch_C, 1'b1, 32'h80);
    do_reset();
    // 2: taken branch allocates WeakT, visible the next cycle
    run_insn(32'h100, Branch_C, 1'b1, 32'h80, 32'h3C);
    step(32'h100, 1'b0, 1'b0, 1'b0, 1'b0, Step_C, 1'b0, 32'h0);
    // 3: two not-taken to StrongNT, then one taken to WeakNT
    run_insn(32'h100, Branch_C, 1'b0, 32'h0, 32'h3C);
    run_insn(32'h100, Branch_C, 1'b0, 32'h0, 32'h3C);
    step(32'h100, 1'b0, 1'b0, 1'b0, 1'b0, Step_C, 1'b0, 32'h0);
    run_insn(32'h100, Branch_C, 1'b1, 32'h80, 32'h3C);
    step(32'h100, 1'b0, 1'b0, 1'b0, 1'b0, Step_C, 1'b0, 32'h0);
    // 4: aliasing on index 0
    run_insn(32'h100, Branch_C, 1'b1, 32'h80, 32'h140);
    run_insn(32'h140, Branch_C, 1'b1, 32'h500, 32'h3C);
    step(32'h100, 1'b0, 1'b0, 1'b0, 1'b0, Step_C, 1'b0, 32'h0);
    step(32'h140, 1'b0, 1'b0, 1'b0, 1'b0, Step_C, 1'b0, 32'h0);
    // 5: jump allocation, correct pass, target change, stalled in C
    run_insn(32'h200, Jump_C, 1'b0, 32'h300, 32'h3C);
    run_insn(32'h200, Jump_C, 1'b0, 32'h300, 32'h3C);
    run_insn(32'h200, Jump_C, 1'b0, 32'h304, 32'h200);
    step(32'h200, 1'b1, 1'b0, 1'b1, 1'b0, Step_C, 1'b0, 32'h0);
    step(32'h3C,  1'b1, 1'b0, 1'b1, 1'b0, Step_C, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) step(32'h200, 1'b0, 1'b0, 1'b0, 1'b0, Jump_C, 1'b1, 32'h300);
    step(32'h200, 1'b1, 1'b0, 1'b1, 1'b0, Jump_C, 1'b1, 32'h300);
    step(32'h200, 1'b0, 1'b0, 1'b0, 1'b0, Step_C, 1'b0, 32'h0);
    // stalled not-taken branch: a repeated write would push it further down
    run_insn(32'h104, Branch_C, 1'b1, 32'h80, 32'h3C);
    step(32'h104, 1'b1, 1'b0, 1'b1, 1'b0, Step_C, 1'b0, 32'h0);
    step(32'h3C,  1'b1, 1'b0, 1'b1, 1'b0, Step_C, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) step(32'h104, 1'b0, 1'b0, 1'b0, 1'b0, Branch_C, 1'b0, 32'h0);
    step(32'h104, 1'b1, 1'b0, 1'b1, 1'b0, Branch_C, 1'b0, 32'h0);
    run_insn(32'h104, Branch_C, 1'b1, 32'h80, 32'h104);
    step(32'h104, 1'b0, 1'b0, 1'b0, 1'b0, Step_C, 1'b0, 32'h0);
    // 6: write and lookup of the same PC in one cycle return the old entry
    run_insn(32'h100, Branch_C, 1'b1, 32'h80, 32'h3C);
    run_insn(32'h100, Branch_C, 1'b1, 32'h90, 32'h100);
    step(32'h100, 1'b0, 1'b0, 1'b0, 1'b0, Step_C, 1'b0, 32'h0);
    // flushed C never trains
    step(32'h600, 1'b1, 1'b0, 1'b1, 1'b0, Step_C, 1'b0, 32'h0);
    step(32'h3C,  1'b1, 1'b0, 1'b1, 1'b0, Step_C, 1'b0, 32'h0);
    step(32'h3C,  1'b1, 1'b0, 1'b1, 1'b1, Branch_C, 1'b1, 32'h700);
    step(32'h600, 1'b0, 1'b0, 1'b0, 1'b0, Step_C, 1'b0, 32'h0);
    // reset mid-run empties the table
    do_reset();
    step(32'h100, 1'b0, 1'b0, 1'b0, 1'b0, Step_C, 1'b0, 32'h0);
    step(32'h104, 1'b0, 1'b0, 1'b0, 1'b0, Step_C, 1'b0, 32'h0);
    // randomized phase
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        step(pcs[$urandom_range(0, 7)],
             ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
             srcs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
             tgts[$urandom_range(0, 5)]);
      end
    end
    done = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
